condicionador_botoes: RTL
=========================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable cycles needed to accept an input change (1 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-004 SHALL have port: botoes_in  input  4  raw, asynchronous, bouncing push-button levels (1 = pressed).
REQ-005 SHALL have port: jogar_in  input  1  raw, asynchronous start button level.
REQ-006 SHALL have port: botoes  output  4  clean one-hot play code; feeds the game's botoes input.
REQ-007 SHALL have port: jogada_pulso  output  1  one-cycle strobe on acceptance of a valid single-button press.
REQ-008 SHALL have port: jogar  output  1  one-cycle strobe on debounced rising edge of jogar_in; feeds the game's jogar input.
REQ-009 SHALL have port: db_multiplo  output  1  high while in state INVALIDO.
REQ-010 SHALL have port: db_estado  output  2  FSM state code (REPOUSO=0, PRESO=1, INVALIDO=2).

Function
REQ-011 SHALL pass each of the 5 raw inputs through its own 2-flop synchronizer before any other use.
REQ-012 SHALL keep, per input, a debounced level register and a saturating counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 SHALL clear the counter in any cycle where the synchronized value equals the debounced level.
REQ-014 SHALL increment the counter in each cycle where they differ; on the cycle the count reaches DEBOUNCE_CYCLES the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 SHALL restart the count from zero on any bounce (return to agreement) before DEBOUNCE_CYCLES is reached; the debounced level SHALL not change.
REQ-016 SHALL implement a 3-state registered FSM on the debounced 4-bit vector d.
REQ-017 SHALL transition REPOUSO -> PRESO when d has exactly one bit set, latching that one-hot code into botoes and asserting jogada_pulso for that single cycle.
REQ-018 SHALL transition REPOUSO -> INVALIDO when d has two or more bits set; no pulse, botoes = 0.
REQ-019 SHALL hold PRESO, with botoes keeping the latched code and no further pulse, while d != 0, even if additional buttons become set.
REQ-020 SHALL transition PRESO -> REPOUSO when d == 0, with botoes = 0 from that cycle.
REQ-021 SHALL transition INVALIDO -> REPOUSO only when d == 0.
REQ-022 SHALL force botoes = 0 in REPOUSO and INVALIDO.
REQ-023 SHALL register all outputs (no combinational path from inputs to outputs).
REQ-024 SHALL meet this latency: for a raw change applied before edge k and held clean, the debounced level updates at edge k+1+DEBOUNCE_CYCLES and FSM outputs/jogar update at edge k+2+DEBOUNCE_CYCLES.
REQ-025 SHALL generate jogar independently of the FSM: high for one cycle after the debounced jogar level goes 0->1; never on 1->0.
REQ-026 SHALL give strictly one jogada_pulso per press-release cycle, and one jogar per press, regardless of hold duration.

Reset
REQ-027 SHALL, while reset = 1, asynchronously clear synchronizers, debounced levels, counters and outputs to 0, with FSM = REPOUSO.
REQ-028 SHALL, after reset release with a button still held, treat that button as a new press: after the full debounce latency, one jogada_pulso is issued.
REQ-029 SHALL, on reset asserted mid-count or in PRESO, abort the count/press with no pulse emitted.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 SHALL test a clean press: botoes_in 0000->0100 before edge 10 -> jogada_pulso high only after edge 16; botoes = 0100 from edge 16 until release is debounced.
REQ-031 SHALL test bounce rejection: botoes_in toggling 0001/0000 every 2 cycles for 20 cycles -> no pulse, botoes = 0000, FSM stays REPOUSO.
REQ-032 SHALL test a multi-press: 1001 applied at once -> db_multiplo = 1, db_estado = 2, no pulse; release -> back to REPOUSO; then a 0010 press -> one pulse with botoes = 0010.
REQ-033 SHALL test a held press with a later second button: 0001 then 0011 -> exactly one pulse, botoes stays 0001 until 0000 is debounced.
REQ-034 SHALL test jogar held 100 cycles -> exactly one jogar pulse, 6 edges after the change.
REQ-035 SHALL test reset mid-press (in PRESO with 1000 held): outputs go 0 immediately; after release of reset, one pulse with 1000 follows the full debounce latency.

Source files
------------

// File: rtl/condicionador_botoes.sv
// Button conditioner: per-input 2-flop synchronizer and counter debouncer, plus
// a press-classification FSM producing a clean one-hot play code and strobes.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       jogar_in,
  output logic [3:0] botoes,
  output logic       jogada_pulso,
  output logic       jogar,
  output logic       db_multiplo,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REPOUSO  = 2'd0;
  localparam logic [1:0] PRESO    = 2'd1;
  localparam logic [1:0] INVALIDO = 2'd2;

  logic [4:0] raw;
  logic [4:0] level;

  assign raw = {jogar_in, botoes_in};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_db
      logic          s1_q, s2_q, lvl_q;
      logic [CW-1:0] cnt_q;

      // The level flips on the cycle the disagreement count would reach DEBOUNCE_CYCLES.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          lvl_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q <= raw[gi];
          s2_q <= s1_q;
          if (s2_q == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            lvl_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign level[gi] = lvl_q;
    end
  endgenerate

  logic [3:0] d;
  logic       d_one_hot;
  logic [1:0] state_q, state_d;
  logic [3:0] botoes_q, botoes_d;
  logic       pulso_q, pulso_d;
  logic       mult_q;
  logic       jogar_q, jogar_prev_q;

  assign d         = level[3:0];
  assign d_one_hot = (d != 4'd0) && ((d & 4'(d - 4'd1)) == 4'd0);

  always_comb begin
    state_d  = state_q;
    botoes_d = botoes_q;
    pulso_d  = 1'b0;
    case (state_q)
      REPOUSO: begin
        botoes_d = 4'd0;
        if (d_one_hot) begin
          state_d  = PRESO;
          botoes_d = d;
          pulso_d  = 1'b1;
        end else if (d != 4'd0) begin
          state_d = INVALIDO;
        end
      end
      PRESO: begin
        // Extra buttons while held are ignored; only full release ends the press.
        if (d == 4'd0) begin
          state_d  = REPOUSO;
          botoes_d = 4'd0;
        end
      end
      INVALIDO: begin
        botoes_d = 4'd0;
        if (d == 4'd0) state_d = REPOUSO;
      end
      default: begin
        state_d  = REPOUSO;
        botoes_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= REPOUSO;
      botoes_q     <= 4'd0;
      pulso_q      <= 1'b0;
      mult_q       <= 1'b0;
      jogar_q      <= 1'b0;
      jogar_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      botoes_q     <= botoes_d;
      pulso_q      <= pulso_d;
      mult_q       <= (state_d == INVALIDO);
      jogar_prev_q <= level[4];
      jogar_q      <= level[4] & ~jogar_prev_q;
    end
  end

  assign botoes       = botoes_q;
  assign jogada_pulso = pulso_q;
  assign jogar        = jogar_q;
  assign db_multiplo  = mult_q;
  assign db_estado    = state_q;

endmodule
